// File: rtl/game_pair_collision_scanner.sv
// game_pair_collision_scanner
//   Frame-sequential pairwise collision engine. On start (IDLE only) all target
//   boxes and the alive mask are snapshotted, then one unordered pair (i<j) is
//   evaluated per clock in lexicographic order. Each pair owns an immunity
//   counter that suppresses re-hits for IMMUNITY_FRAMES frames.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             frame trigger, ignored unless idle
//   alive             per-target enable, captured with the snapshot
//   sprite_left/right box x bounds (right exclusive)
//   sprite_top/bottom box y bounds (bottom exclusive)
//   busy              high while scanning and in the done cycle
//   done              one-cycle pulse when collide_x/collide_y are published
//   collide_x/y       per-target reflect flags, held until the next done
//   hit_valid/i/j     one-cycle pulse naming each hit pair
`ifndef N_TARGETS
`define N_TARGETS 4
`endif

module game_pair_collision_scanner #(
  parameter int unsigned N_TARGETS       = `N_TARGETS,
  parameter int unsigned W_X             = $clog2(640),
  parameter int unsigned W_Y             = $clog2(480),
  parameter int unsigned IMMUNITY_FRAMES = 5,
  localparam int unsigned W_IDX          = ($clog2(N_TARGETS) < 1) ? 1 : $clog2(N_TARGETS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [N_TARGETS-1:0]            alive,
  input  logic [N_TARGETS-1:0][W_X-1:0]   sprite_left,
  input  logic [N_TARGETS-1:0][W_X-1:0]   sprite_right,
  input  logic [N_TARGETS-1:0][W_Y-1:0]   sprite_top,
  input  logic [N_TARGETS-1:0][W_Y-1:0]   sprite_bottom,
  output logic                            busy,
  output logic                            done,
  output logic [N_TARGETS-1:0]            collide_x,
  output logic [N_TARGETS-1:0]            collide_y,
  output logic                            hit_valid,
  output logic [W_IDX-1:0]                hit_i,
  output logic [W_IDX-1:0]                hit_j
);

  localparam int unsigned P     = N_TARGETS * (N_TARGETS - 1) / 2;
  localparam int unsigned W_K   = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned W_CNT = (IMMUNITY_FRAMES > 0) ? $clog2(IMMUNITY_FRAMES + 1) : 1;
  localparam int unsigned W_M   = (W_X > W_Y) ? W_X : W_Y;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;

  state_e                          state_q, state_d;
  logic [W_K-1:0]                  k_q, k_d;
  logic [W_IDX-1:0]                i_q, i_d, j_q, j_d;
  logic [W_CNT-1:0]                imm_q [P];
  logic [W_CNT-1:0]                imm_d [P];
  logic [N_TARGETS-1:0]            cxw_q, cxw_d, cyw_q, cyw_d;
  logic [N_TARGETS-1:0]            cx_q, cx_d, cy_q, cy_d;
  logic                            hit_valid_q, hit_valid_d;
  logic [W_IDX-1:0]                hit_i_q, hit_i_d, hit_j_q, hit_j_d;

  // Snapshot registers (no reset needed: contents unused until loaded)
  logic                            shadow_load;
  logic [N_TARGETS-1:0]            alive_q;
  logic [N_TARGETS-1:0][W_X-1:0]   left_q, right_q;
  logic [N_TARGETS-1:0][W_Y-1:0]   top_q, bot_q;

  // Overlap and penetration depth for the current pair
  logic                            overlap;
  logic [W_X-1:0]                  x_lo, x_hi, xd_n;
  logic [W_Y-1:0]                  y_lo, y_hi, yd_n;
  logic [W_M-1:0]                  xd, yd;

  always_comb begin
    overlap = (left_q[i_q] < right_q[j_q]) && (right_q[i_q] > left_q[j_q]) &&
              (top_q[i_q]  < bot_q[j_q])   && (bot_q[i_q]   > top_q[j_q]);
    x_hi = (right_q[i_q] < right_q[j_q]) ? right_q[i_q] : right_q[j_q];
    x_lo = (left_q[i_q]  > left_q[j_q])  ? left_q[i_q]  : left_q[j_q];
    y_hi = (bot_q[i_q]   < bot_q[j_q])   ? bot_q[i_q]   : bot_q[j_q];
    y_lo = (top_q[i_q]   > top_q[j_q])   ? top_q[i_q]   : top_q[j_q];
    xd_n = x_hi - x_lo;
    yd_n = y_hi - y_lo;
    xd   = W_M'(xd_n);
    yd   = W_M'(yd_n);
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    i_d         = i_q;
    j_d         = j_q;
    imm_d       = imm_q;
    cxw_d       = cxw_q;
    cyw_d       = cyw_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    hit_valid_d = 1'b0;
    hit_i_d     = hit_i_q;
    hit_j_d     = hit_j_q;
    shadow_load = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_load = 1'b1;
          cxw_d       = '0;
          cyw_d       = '0;
          k_d         = '0;
          i_d         = '0;
          j_d         = W_IDX'(1);
          state_d     = S_SCAN;
        end
      end
      S_SCAN: begin
        // Immunity takes priority over the alive mask so dead pairs still age out.
        if (imm_q[k_q] != '0) begin
          imm_d[k_q] = imm_q[k_q] - W_CNT'(1);
        end else if (alive_q[i_q] && alive_q[j_q] && overlap) begin
          imm_d[k_q]  = W_CNT'(IMMUNITY_FRAMES);
          hit_valid_d = 1'b1;
          hit_i_d     = i_q;
          hit_j_d     = j_q;
          // Shallower axis wins; equal depth reflects on both axes.
          if (xd <= yd) begin
            cxw_d[i_q] = 1'b1;
            cxw_d[j_q] = 1'b1;
          end
          if (yd <= xd) begin
            cyw_d[i_q] = 1'b1;
            cyw_d[j_q] = 1'b1;
          end
        end
        if (k_q == W_K'(P - 1)) begin
          // Publish including the last pair's contribution so the result is
          // visible in the DONE cycle.
          cx_d    = cxw_d;
          cy_d    = cyw_d;
          state_d = S_DONE;
        end else begin
          k_d = k_q + W_K'(1);
          if (j_q == W_IDX'(N_TARGETS - 1)) begin
            i_d = i_q + W_IDX'(1);
            j_d = i_q + W_IDX'(2);
          end else begin
            j_d = j_q + W_IDX'(1);
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      cxw_q       <= '0;
      cyw_q       <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      hit_valid_q <= 1'b0;
      hit_i_q     <= '0;
      hit_j_q     <= '0;
      for (int unsigned p = 0; p < P; p++) imm_q[p] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      i_q         <= i_d;
      j_q         <= j_d;
      cxw_q       <= cxw_d;
      cyw_q       <= cyw_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      hit_valid_q <= hit_valid_d;
      hit_i_q     <= hit_i_d;
      hit_j_q     <= hit_j_d;
      imm_q       <= imm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shadow_load) begin
      alive_q <= alive;
      left_q  <= sprite_left;
      right_q <= sprite_right;
      top_q   <= sprite_top;
      bot_q   <= sprite_bottom;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign collide_x = cx_q;
  assign collide_y = cy_q;
  assign hit_valid = hit_valid_q;
  assign hit_i     = hit_i_q;
  assign hit_j     = hit_j_q;

endmodule

// File: tb/tb_game_pair_collision_scanner.sv
// Scoreboard bench for game_pair_collision_scanner (N=4, P=6, immunity 3).
module tb_game_pair_collision_scanner;

  localparam int unsigned N  = 4;
  localparam int unsigned WX = 10;
  localparam int unsigned WY = 9;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [N-1:0]           alive;
  logic [N-1:0][WX-1:0]   sl, sr;
  logic [N-1:0][WY-1:0]   st, sb;
  logic                   busy, done, hv;
  logic [N-1:0]           cx, cy;
  logic [1:0]             hi, hj;

  game_pair_collision_scanner #(
    .N_TARGETS(4),
    .W_X(10),
    .W_Y(9),
    .IMMUNITY_FRAMES(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .alive(alive),
    .sprite_left(sl), .sprite_right(sr), .sprite_top(st), .sprite_bottom(sb),
    .busy(busy), .done(done), .collide_x(cx), .collide_y(cy),
    .hit_valid(hv), .hit_i(hi), .hit_j(hj)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int cyc; int i; int j; } hit_t;
  typedef struct { int cyc; logic [3:0] cx; logic [3:0] cy; } frm_t;
  hit_t hit_q[$];
  frm_t frm_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a hit or a done.
  always @(negedge clk) begin : monitor
    hit_t he;
    frm_t fe;
    if (hv) begin
      if (hit_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_hit: got (%0d,%0d) expected none (cycle %0d)", hi, hj, cyc);
      end else begin
        he = hit_q.pop_front();
        check("hit_cycle", cyc, he.cyc);
        check("hit_i", int'(hi), he.i);
        check("hit_j", int'(hj), he.j);
      end
    end
    if (done) begin
      if (frm_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
      end else begin
        fe = frm_q.pop_front();
        check("done_cycle", cyc, fe.cyc);
        check("collide_x", int'(cx), int'(fe.cx));
        check("collide_y", int'(cy), int'(fe.cy));
      end
    end
  end

  task automatic set_box(input int b, input int l, input int r, input int t, input int bt);
    sl[b] = WX'(l); sr[b] = WX'(r); st[b] = WY'(t); sb[b] = WY'(bt);
  endtask

  // 0: x-axis overlap, 1: equal depth + edge touch, 2: all far apart
  task automatic cfg(input int c);
    case (c)
      0: begin
        set_box(0, 10, 30, 10, 30);
        set_box(1, 25, 45, 12, 28);
        set_box(2, 100, 110, 100, 110);
        set_box(3, 200, 210, 200, 210);
      end
      1: begin
        set_box(0, 0, 10, 0, 10);
        set_box(1, 5, 15, 5, 15);
        set_box(2, 15, 20, 5, 15);
        set_box(3, 200, 210, 200, 210);
      end
      default: begin
        set_box(0, 300, 310, 300, 310);
        set_box(1, 400, 410, 10, 20);
        set_box(2, 100, 110, 100, 110);
        set_box(3, 200, 210, 200, 210);
      end
    endcase
  endtask

  // One full frame; the only pair that can hit in these scenes is (0,1) = k0.
  task automatic do_frame(input bit exp_hit, input logic [3:0] ecx, input logic [3:0] ecy);
    int t;
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    if (exp_hit) hit_q.push_back('{t + 2, 0, 1});
    frm_q.push_back('{t + 7, ecx, ecy});
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; alive = 4'b1111;
    cfg(0);
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cx", int'(cx), 0);
    check("rst_cy", int'(cy), 0);
    check("rst_hv", int'(hv), 0);
    rst = 1'b0;
    @(negedge clk);

    // Alive mask blocks the hit, then enabling it reports the hit
    alive = 4'b1110;
    do_frame(1'b0, 4'b0000, 4'b0000);
    alive = 4'b1111;
    do_frame(1'b1, 4'b0011, 4'b0000);   // immunity frame 1
    do_frame(1'b0, 4'b0000, 4'b0000);
    do_frame(1'b0, 4'b0000, 4'b0000);
    do_frame(1'b0, 4'b0000, 4'b0000);
    do_frame(1'b1, 4'b0011, 4'b0000);   // immunity frame 5
    do_frame(1'b0, 4'b0000, 4'b0000);

    // Busy rejection; both scans also age the (0,1) counter down to 0
    cfg(2);
    @(negedge clk);
    start = 1'b1; t = cyc;
    frm_q.push_back('{t + 7, 4'b0000, 4'b0000});
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    check("busy_scan", int'(busy), 1);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_idle", int'(busy), 0);
    start = 1'b1;
    frm_q.push_back('{t + 15, 4'b0000, 4'b0000});
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);

    // Equal depth: both axes; touching pair (1,2) must not hit
    cfg(1);
    do_frame(1'b1, 4'b0011, 4'b0011);

    // Reset mid-scan while (0,1) is immune
    @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_cx", int'(cx), 0);
    check("midrst_cy", int'(cy), 0);
    check("midrst_hv", int'(hv), 0);
    rst = 1'b0;
    @(negedge clk);
    do_frame(1'b1, 4'b0011, 4'b0011);

    repeat (3) @(negedge clk);
    check("hits_outstanding", hit_q.size(), 0);
    check("frames_outstanding", frm_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_pair_collision_scanner.md
# game_pair_collision_scanner

Frame-sequential, parametrised pairwise collision engine for game targets. On each `start` it snapshots all target bounding boxes and then evaluates one unordered pair per clock. Each pair has a frame-counted immunity window. The block picks the bounce axis from the overlap depth, skips dead targets, and reports per-pair hit events. It sits between the sprite position logic and the target motion/reflection logic and is triggered once per video frame.

## Interface
- `N_TARGETS`, default `` `N_TARGETS `` (game_config.svh), number of targets, ≥2
- `W_X`, default `$clog2(640)`, horizontal coordinate width
- `W_Y`, default `$clog2(480)`, vertical coordinate width
- `IMMUNITY_FRAMES`, default 5, number of frames a pair is skipped after a hit; 0 disables immunity
- `W_IDX` (derived), `max(1,$clog2(N_TARGETS))`
- `P` (derived), `N_TARGETS*(N_TARGETS-1)/2`, pair count

Ports:
- `clk`  in  1  sole clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  frame trigger; accepted only in IDLE
- `alive`  in  N_TARGETS  per-target enable; sampled with the snapshot
- `sprite_left`, `sprite_right`  in  N_TARGETS×W_X  box x bounds, right exclusive
- `sprite_top`, `sprite_bottom`  in  N_TARGETS×W_Y  box y bounds, bottom exclusive
- `busy`  out  1  high in SCAN and DONE
- `done`  out  1  one-cycle pulse when results are published
- `collide_x`  out  N_TARGETS  target must reflect horizontally
- `collide_y`  out  N_TARGETS  target must reflect vertically
- `hit_valid`  out  1  one-cycle pulse per detected pair hit
- `hit_i`, `hit_j`  out  W_IDX  indices of the hit pair, i<j

## Operation
- States:
  - IDLE: `start`=1 captures all box inputs and `alive` into shadow registers, clears the working collide vectors, sets pair pointer k=0 (i=0, j=1), then goes to SCAN.
  - SCAN: evaluates pair k. Pair order is lexicographic: (0,1),(0,2)…(0,N-1),(1,2)…(N-2,N-1). After k=P-1 it goes to DONE.
  - DONE: lasts one cycle, then goes to IDLE.
- `start` in SCAN or DONE is ignored and is not queued.
- One immunity counter per pair, W = `$clog2(IMMUNITY_FRAMES+1)` bits (at least 1). Each pair is evaluated as follows:
  1. If counter≠0: counter decrements by 1 and the pair is skipped. This applies even when the pair is not alive.
  2. Otherwise, if `alive[i]&alive[j]`=0: skip; the counter stays 0.
  3. Otherwise, test overlap: `l_i<r_j && r_i>l_j && t_i<b_j && b_i>t_j`. This uses strict comparisons, so touching edges do not overlap.
  4. On overlap:
     - xd = min(r_i,r_j)−max(l_i,l_j) and yd = min(b_i,b_j)−max(t_i,t_j), unsigned, compared zero-extended to max(W_X,W_Y).
     - xd<yd sets working x bits i,j only. yd<xd sets working y bits i,j only. xd==yd sets both.
     - The counter loads IMMUNITY_FRAMES.
     - `hit_valid`/`hit_i`/`hit_j` are registered for the next cycle.
- Working collide bits OR-accumulate across pairs within a frame.
- Net effect: a pair hit in frame f is skipped in frames f+1…f+IMMUNITY_FRAMES and evaluated again in frame f+IMMUNITY_FRAMES+1.
- Reset (at any time, including mid-scan): state goes to IDLE and all counters clear to 0. Every output resets to 0: `busy`, `done`, `collide_x`, `collide_y`, `hit_valid`, `hit_i`, `hit_j`. Shadow contents are don't-care.

## Timing
- With `start` accepted at the edge ending cycle T:
  - SCAN occupies cycles T+1…T+P; pair k is evaluated in cycle T+1+k.
  - `hit_valid` for pair k is high in cycle T+2+k.
  - DONE is cycle T+P+1. `done`=1 in that cycle, and `collide_x`/`collide_y` show the new frame's values from that cycle on. They hold until the next DONE.
  - IDLE resumes at T+P+2, where `start` can be accepted again. Minimum frame period is P+2 cycles.
- The last pair's hit pulse coincides with `done`.
- Inputs may change freely after the snapshot edge without affecting the current scan.

## Test plan
- Reset: assert `rst` mid-scan (N=4, P=6) → next cycle `busy`=0, `done`=0, collide vectors 0000, `hit_valid`=0. The next frame with an overlapping pair hits even though that pair was immune before reset.
- X-axis hit (N=4, F=3): box0 [10,30)×[10,30), box1 [25,45)×[12,28) (xd=5, yd=16), boxes 2/3 far away, `start` at T → `hit_valid` at T+2 with (0,1); `done` at T+7; `collide_x`=0011, `collide_y`=0000.
- Equal depth and edge touch: box0 [0,10)×[0,10), box1 [5,15)×[5,15), box2 [15,20)×[5,15) → only pair (0,1) hits; `collide_x`=`collide_y`=0011. The touching pair (1,2) does not hit.
- Immunity: the X-axis configuration held for 6 frames with F=3 → hits in frames 1 and 5 only; `collide_x`=0011 in frames 1 and 5, 0000 otherwise.
- Alive mask: same overlap with `alive`=1110 → no hit, `collide_x`=0000. Switching to `alive`=1111 in the next frame → hit is reported.
- Busy rejection: pulse `start` again at T+3 → ignored; exactly one `done` at T+7; a `start` at T+8 is accepted and gives `done` at T+15.
